// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor. CHUNK bits of each operand are
// summed per clock through a CHUNK-slice full-adder ripple, with the carry held
// in a register between steps. Operands are captured on start; the result is
// published after WIDTH/CHUNK steps together with carry-out and overflow.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = $clog2(N + 1);

   // Refuse to elaborate with a chunk size that does not tile the operand.
   generate
      if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("serial_adder: CHUNK must divide WIDTH and WIDTH must be at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    step_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   // Ripple carries: rc[0] is the carry register, rc[CHUNK] leaves the chunk.
   logic [CHUNK:0]   rc;
   logic [CHUNK-1:0] slice_sum;
   logic [WIDTH-1:0] res_d;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] b_d;
   logic [CW-1:0]    step_d;
   logic             last_step;
   logic             c_msb_in;
   logic             c_msb_out;

   assign rc[0] = carry_q;

   // One full-adder slice per bit of the chunk, chained through rc.
   generate
      for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
         assign slice_sum[gi] = a_q[gi] ^ b_q[gi] ^ rc[gi];
         assign rc[gi+1]      = (a_q[gi] & b_q[gi]) | (rc[gi] & (a_q[gi] ^ b_q[gi]));
      end
   endgenerate

   // The carry into the top bit of the last chunk is the ripple tap just below
   // the chunk MSB; for a one-bit chunk that tap is the carry register itself.
   assign c_msb_in  = rc[CHUNK-1];
   assign c_msb_out = rc[CHUNK];

   // Next-step datapath: operands shift out low-first, sum bits enter at the top.
   always_comb begin
      a_d       = a_q >> CHUNK;
      b_d       = b_q >> CHUNK;
      res_d     = (res_q >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));
      step_d    = step_q + 1'b1;
      last_step = (step_q == CW'(N - 1));
   end

   // Control FSM plus all datapath and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         step_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  // Subtraction is a + ~b + 1: invert B and force the carry in.
                  state_q <= RUN;
                  step_q  <= '0;
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub ? 1'b1 : cin;
                  res_q   <= '0;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               a_q     <= a_d;
               b_q     <= b_d;
               res_q   <= res_d;
               carry_q <= c_msb_out;
               step_q  <= step_d;
               if (last_step) begin
                  state_q <= DONE;
                  sum_q   <= res_d;
                  cout_q  <= c_msb_out;
                  ovf_q   <= c_msb_in ^ c_msb_out;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor, successor to the single-bit full-adder cell `count`. It processes `CHUNK` bits of each operand per clock using a ripple of `CHUNK` full-adder slices and a registered carry. Operands are latched on a `start`/`busy`/`done` handshake, and the result appears after a fixed latency of `WIDTH/CHUNK` cycles. It gives the datapath wide add/subtract at small area, in place of a `WIDTH`-bit combinational adder.

## Interface

- `WIDTH`, 8, operand and result width in bits; must be at least 2.
- `CHUNK`, 1, bits processed per cycle; must divide `WIDTH` exactly. Elaboration fails otherwise.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only when `busy`=0.
- `sub`  input  1  mode: 0 = `a+b+cin`, 1 = `a-b` (computed as `a+~b+1`; `cin` ignored).
- `a`  input  `WIDTH`  operand A; sampled with `start`.
- `b`  input  `WIDTH`  operand B; sampled with `start`.
- `cin`  input  1  carry-in for add mode; sampled with `start`.
- `busy`  output  1  computation in progress.
- `done`  output  1  one-cycle pulse; the result registers were updated on the preceding edge.
- `sum`  output  `WIDTH`  result; held stable between completions.
- `cout`  output  1  carry-out. In sub mode, 1 means no borrow (`a>=b` unsigned).
- `ovf`  output  1  two's-complement overflow: carry into the MSB XOR carry out of the MSB.

## Operation

- `N` = `WIDTH/CHUNK` steps. The step counter is `clog2(N+1)` bits wide.
- States: `IDLE`, `RUN`, `DONE`.
- **IDLE -> RUN** when `start`=1.
  - Latch `a` into shift register A.
  - Latch `b`, or `~b` when `sub`=1, into shift register B.
  - Set the carry register to `cin`, or to 1 when `sub`=1.
  - Clear the step counter and the internal result shift register.
- **RUN**, each edge:
  - Add the low `CHUNK` bits of A and B plus the carry register.
  - Store the carry-out in the carry register.
  - Shift A and B right by `CHUNK`.
  - Shift the `CHUNK` sum bits into the top of the result register.
  - Increment the step counter.
- **RUN -> DONE** on the edge that completes step `N`.
  - Load `sum` with the final result register.
  - Load `cout` with the final carry.
  - Load `ovf` with `c_msb_in ^ c_msb_out`. `c_msb_in` is the carry into the top bit of the last chunk; it comes from the internal ripple when `CHUNK`>1 and from the carry register when `CHUNK`=1.
- **DONE -> RUN** if `start`=1 (back-to-back operation, same latch actions as from IDLE). Otherwise **DONE -> IDLE**.
- `start` is ignored while in RUN. No queuing; the request is dropped.
- `sum`, `cout` and `ovf` change only on the completion edge. Changes to `a`, `b`, `sub` or `cin` after the start edge have no effect.
- `busy` = (state == RUN). `done` = (state == DONE). Both are registered-state decodes with no combinational path from inputs.
- **Reset** (asserted at any time, including mid-RUN): state IDLE, step counter 0, all shift registers 0, carry register 0, `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0. A partial computation is discarded, and no `done` is produced for it.

## Timing

- `start` seen at edge E0:
  - `busy`=1 during the N cycles after E0.
  - The results update at edge E0+N.
  - `done`=1 for the cycle after E0+N, with `busy`=0 in that cycle.
- Latency is `N` cycles from the start edge to valid `sum`. Throughput is one operation per `N+1` cycles.
- `WIDTH`=8: `CHUNK`=1 gives `N`=8; `CHUNK`=4 gives `N`=2; `CHUNK`=8 gives `N`=1 (degenerate single-step case; it must still pass through RUN for exactly one cycle).
- The critical path is one `CHUNK`-bit ripple plus a register setup.

## Test plan

- **Reset values**: `rst_n`=0 -> all outputs 0; release, no `start` -> outputs stay 0 and state stays IDLE.
- **Add, `WIDTH`=8, `CHUNK`=1**: `a`=0x5A, `b`=0x3C, `cin`=1 -> `busy` high for 8 cycles, then `done` pulse with `sum`=0x97, `cout`=0, `ovf`=1.
- **Subtract / borrow**:
  - `sub`=1, `a`=0x10, `b`=0x20 -> `sum`=0xF0, `cout`=0, `ovf`=0.
  - `a`=0x80, `b`=0x01 -> `sum`=0x7F, `cout`=1, `ovf`=1.
- **Wrap-around, `CHUNK`=4**: `a`=0xFF, `b`=0x01, `cin`=0 -> `done` after 2 cycles, `sum`=0x00, `cout`=1, `ovf`=0.
- **Handshake corners**:
  - `start` pulses during `busy` -> ignored; the result equals the first operation's result.
  - `start` held high in the DONE cycle with new operands 0x01+0x01 -> the next `done` follows after exactly N+1 cycles with `sum`=0x02.
  - Operands changed mid-RUN -> the result is unaffected.
- **Reset mid-operation**: assert `rst_n`=0 at RUN step 3 -> outputs 0, no `done`; the next operation 0x22+0x11 completes correctly with `sum`=0x33. Plus a randomised sweep of 1000 operations per `CHUNK` in {1,2,4,8} against a reference model.
